// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N producers.
// Each grant covers a burst of up to BURST words and ends early when the owner withdraws its request.
module fifo_wr_arbiter #(
   parameter int B     = 3,
   parameter int N     = 4,
   parameter int BURST = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N*B-1:0] din,
   output logic [N-1:0]   ack,
   output logic [N-1:0]   grant,
   output logic           busy,
   input  logic           fifo_full,
   output logic           fifo_wr,
   output logic [B-1:0]   fifo_w_data
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   sel;
   logic [IW-1:0]   nxt_ptr;
   logic [CW-1:0]   cnt;
   logic            found;
   logic            wr_ok;
   logic            burst_done;
   logic [B-1:0]    words [N];
   int unsigned     idx;

   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         words[i] = din[i*B +: B];
      end
   end

   // Search starts at ptr and wraps, so the first hit is the highest-priority requester
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = IW'(idx);
         end
      end
   end

   assign wr_ok      = (state == GRANT) && req[owner] && !fifo_full;
   assign burst_done = wr_ok && ((cnt + 1'b1) == CW'(BURST));
   assign nxt_ptr    = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;

   always_comb begin
      ack         = '0;
      fifo_wr     = wr_ok;
      fifo_w_data = '0;
      if (state == GRANT) begin
         fifo_w_data = words[owner];
         ack[owner]  = wr_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         owner <= '0;
         ptr   <= '0;
         cnt   <= '0;
         grant <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  state <= GRANT;
                  owner <= sel;
                  grant <= {{(N-1){1'b0}}, 1'b1} << sel;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            GRANT: begin
               if (wr_ok) begin
                  cnt <= cnt + 1'b1;
               end
               // A full FIFO keeps the grant: cnt frozen, owner retained
               if (burst_done || !req[owner]) begin
                  state <= IDLE;
                  grant <= '0;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  ptr   <= nxt_ptr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
